conv_window_gen: RTL and testbench



---
 rtl/conv_pkg.sv | 23 ++
 rtl/conv_line_buf.sv | 31 +++
 rtl/conv_window_gen.sv | 209 ++++++++++++++++++++
 tb/tb_conv_window_gen.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : conv_pkg
// Purpose  : Shared widths, default frame geometry and pixel type for the
//            3x3 convolution window generator.
// Revision : 1.0 - initial release
// ============================================================================
package conv_pkg;

  localparam int DATA_W      = 8;
  localparam int KERNEL_TAPS = 9;
  localparam int DEF_IMG_W   = 8;
  localparam int DEF_IMG_H   = 8;

  typedef logic [DATA_W-1:0] pix_t;

  // Counter/address width for a range of n values; never returns zero.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_line_buf.sv
`default_nettype none
// ============================================================================
// Module   : conv_line_buf
// Purpose  : DEPTH-entry single-clock delay line; the read port returns the
//            old entry at the write address (read-before-write).
// Revision : 1.0 - initial release
// ============================================================================
module conv_line_buf
  import conv_pkg::*;
#(
  parameter int DEPTH = DEF_IMG_W
) (
  input  logic                      clk,
  input  logic [cnt_w(DEPTH)-1:0]   addr_i,
  input  logic                      wr_en_i,
  input  pix_t                      wr_data_i,
  output pix_t                      rd_data_o
);

  pix_t mem_q [DEPTH];

  assign rd_data_o = mem_q[addr_i];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[addr_i] <= wr_data_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/conv_window_gen.sv
`default_nettype none
// ============================================================================
// Module   : conv_window_gen
// Purpose  : Streaming 3x3 window generator with valid/ready on both sides.
//            Define CONV_WIN_KERNEL_LOAD_EN for a loadable 9-tap kernel;
//            otherwise the taps form a fixed identity kernel.
// Revision : 1.0 - initial release
// ============================================================================
module conv_window_gen #(
  parameter int IMG_W  = conv_pkg::DEF_IMG_W,
  parameter int IMG_H  = conv_pkg::DEF_IMG_H,
  parameter int DATA_W = conv_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] pix_in,
  input  logic              pix_valid,
  output logic              pix_ready,
  output logic [DATA_W-1:0] x11,
  output logic [DATA_W-1:0] x12,
  output logic [DATA_W-1:0] x13,
  output logic [DATA_W-1:0] x21,
  output logic [DATA_W-1:0] x22,
  output logic [DATA_W-1:0] x23,
  output logic [DATA_W-1:0] x31,
  output logic [DATA_W-1:0] x32,
  output logic [DATA_W-1:0] x33,
  output logic [DATA_W-1:0] k11,
  output logic [DATA_W-1:0] k12,
  output logic [DATA_W-1:0] k13,
  output logic [DATA_W-1:0] k21,
  output logic [DATA_W-1:0] k22,
  output logic [DATA_W-1:0] k23,
  output logic [DATA_W-1:0] k31,
  output logic [DATA_W-1:0] k32,
  output logic [DATA_W-1:0] k33,
  input  logic [DATA_W-1:0] k_in,
  input  logic              k_load,
  output logic              win_valid,
  input  logic              win_ready,
  output logic              frame_end
);

  import conv_pkg::*;

  localparam int c_COL_W = cnt_w(IMG_W);
  localparam int c_ROW_W = cnt_w(IMG_H);
  localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(IMG_W - 1);
  localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(IMG_H - 1);
  localparam logic [c_COL_W-1:0] c_COL_TWO  = c_COL_W'(2);
  localparam logic [c_ROW_W-1:0] c_ROW_TWO  = c_ROW_W'(2);

  logic [c_COL_W-1:0] col_q, col_d;
  logic [c_ROW_W-1:0] row_q, row_d;
  logic               win_valid_q, win_valid_d;
  logic               last_win_q, last_win_d;
  logic               frame_end_q, frame_end_d;
  pix_t               win_q [3][3];
  pix_t               win_d [3][3];

  logic w_accept;
  logic w_consume;
  logic w_col_last;
  logic w_row_last;
  logic w_completes;
  pix_t w_lb1_rd;
  pix_t w_lb2_rd;

  assign pix_ready   = !win_valid_q || win_ready;
  assign w_accept    = pix_valid && pix_ready;
  assign w_consume   = win_valid_q && win_ready;
  assign w_col_last  = (col_q == c_COL_LAST);
  assign w_row_last  = (row_q == c_ROW_LAST);
  assign w_completes = (row_q >= c_ROW_TWO) && (col_q >= c_COL_TWO);

  // Row r-1 buffer feeds the row r-2 buffer, so both advance on one address.
  conv_line_buf #(
    .DEPTH (IMG_W)
  ) u_lb_r1 (
    .clk       (clk),
    .addr_i    (col_q),
    .wr_en_i   (w_accept),
    .wr_data_i (pix_in),
    .rd_data_o (w_lb1_rd)
  );

  conv_line_buf #(
    .DEPTH (IMG_W)
  ) u_lb_r2 (
    .clk       (clk),
    .addr_i    (col_q),
    .wr_en_i   (w_accept),
    .wr_data_i (w_lb1_rd),
    .rd_data_o (w_lb2_rd)
  );

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    win_d       = win_q;
    win_valid_d = win_valid_q;
    last_win_d  = last_win_q;
    frame_end_d = w_consume && last_win_q;

    if (w_consume) begin
      win_valid_d = 1'b0;
    end

    if (w_accept) begin
      col_d = w_col_last ? '0 : col_q + 1'b1;
      if (w_col_last) begin
        row_d = w_row_last ? '0 : row_q + 1'b1;
      end

      for (int i = 0; i < 3; i++) begin
        win_d[i][0] = win_q[i][1];
        win_d[i][1] = win_q[i][2];
      end
      win_d[0][2] = w_lb2_rd;
      win_d[1][2] = w_lb1_rd;
      win_d[2][2] = pix_in;

      if (w_completes) begin
        win_valid_d = 1'b1;
        last_win_d  = w_col_last && w_row_last;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q       <= '0;
      row_q       <= '0;
      win_q       <= '{default: '0};
      win_valid_q <= 1'b0;
      last_win_q  <= 1'b0;
      frame_end_q <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      win_q       <= win_d;
      win_valid_q <= win_valid_d;
      last_win_q  <= last_win_d;
      frame_end_q <= frame_end_d;
    end
  end

  assign win_valid = win_valid_q;
  assign frame_end = frame_end_q;

  assign x11 = win_q[0][0];
  assign x12 = win_q[0][1];
  assign x13 = win_q[0][2];
  assign x21 = win_q[1][0];
  assign x22 = win_q[1][1];
  assign x23 = win_q[1][2];
  assign x31 = win_q[2][0];
  assign x32 = win_q[2][1];
  assign x33 = win_q[2][2];

`ifdef CONV_WIN_KERNEL_LOAD_EN
  pix_t k_q [KERNEL_TAPS];
  pix_t k_d [KERNEL_TAPS];

  // Loads are frozen while a window is presented so taps match its pixels.
  always_comb begin
    k_d = k_q;
    if (k_load && !win_valid_q) begin
      for (int t = 0; t < KERNEL_TAPS - 1; t++) begin
        k_d[t] = k_q[t+1];
      end
      k_d[KERNEL_TAPS-1] = k_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      k_q <= '{default: '0};
    end else begin
      k_q <= k_d;
    end
  end

  assign k11 = k_q[0];
  assign k12 = k_q[1];
  assign k13 = k_q[2];
  assign k21 = k_q[3];
  assign k22 = k_q[4];
  assign k23 = k_q[5];
  assign k31 = k_q[6];
  assign k32 = k_q[7];
  assign k33 = k_q[8];
`else
  logic w_unused_k;
  assign w_unused_k = ^{k_in, k_load};

  assign k11 = '0;
  assign k12 = '0;
  assign k13 = '0;
  assign k21 = '0;
  assign k22 = DATA_W'(1);
  assign k23 = '0;
  assign k31 = '0;
  assign k32 = '0;
  assign k33 = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_conv_window_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_conv_window_gen
// Purpose  : Self-checking bench for conv_window_gen on a 5x5 frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_window_gen;

  localparam int W = 5;
  localparam int H = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] pix_in;
  logic       pix_valid;
  logic       pix_ready;
  logic [7:0] x11, x12, x13, x21, x22, x23, x31, x32, x33;
  logic [7:0] k11, k12, k13, k21, k22, k23, k31, k32, k33;
  logic [7:0] k_in;
  logic       k_load;
  logic       win_valid;
  logic       win_ready;
  logic       frame_end;

  conv_window_gen #(
    .IMG_W  (W),
    .IMG_H  (H),
    .DATA_W (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pix_in    (pix_in),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .x11 (x11), .x12 (x12), .x13 (x13),
    .x21 (x21), .x22 (x22), .x23 (x23),
    .x31 (x31), .x32 (x32), .x33 (x33),
    .k11 (k11), .k12 (k12), .k13 (k13),
    .k21 (k21), .k22 (k22), .k23 (k23),
    .k31 (k31), .k32 (k32), .k33 (k33),
    .k_in      (k_in),
    .k_load    (k_load),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .frame_end (frame_end)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         done_pix;
    logic [7:0] e11;
    logic [7:0] e22;
    logic [7:0] e33;
  } win_rec_t;

  win_rec_t    tbl [9];
  int          tests = 0;
  int          fails = 0;
  bit          mon_en = 1'b0;
  logic [7:0]  img [H][W];
  int          m_row = 0;
  int          m_col = 0;
  bit          m_con;
  bit          m_acc;
  logic [71:0] sb_q [$];
  bit          last_q [$];
  bit          exp_wv = 1'b0;
  bit          exp_fe = 1'b0;
  logic [71:0] cap_log [$];
  int          win_cnt = 0;
  int          fe_cnt = 0;

  localparam logic [71:0] K_IDENT  = 72'h00_00_00_00_01_00_00_00_00;
  localparam logic [71:0] K_LOADED = 72'h01_02_03_04_05_06_07_08_09;
  localparam logic [71:0] WIN_F0   = 72'h00_01_02_05_06_07_0a_0b_0c;
  localparam logic [71:0] WIN_F0_N = 72'h01_02_03_06_07_08_0b_0c_0d;
  localparam logic [71:0] WIN_F100 = 72'h64_65_66_69_6a_6b_6e_6f_70;

  function automatic logic [71:0] xvec();
    return {x11, x12, x13, x21, x22, x23, x31, x32, x33};
  endfunction

  function automatic logic [71:0] kvec();
    return {k11, k12, k13, k21, k22, k23, k31, k32, k33};
  endfunction

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Monitor and reference model: sampled on the falling edge, mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("win_valid", 72'(win_valid), 72'(exp_wv));
        chk("frame_end", 72'(frame_end), 72'(exp_fe));
        chk("pix_ready", 72'(pix_ready), 72'(!exp_wv || win_ready));
        if (exp_wv && sb_q.size() > 0) chk("window", xvec(), sb_q[0]);
        if (win_valid && win_ready) begin
          win_cnt++;
          cap_log.push_back(xvec());
        end
        if (frame_end) fe_cnt++;

        if (reset) begin
          m_row  = 0;
          m_col  = 0;
          exp_wv = 1'b0;
          exp_fe = 1'b0;
          sb_q.delete();
          last_q.delete();
        end else begin
          m_con  = exp_wv && win_ready;
          m_acc  = pix_valid && (!exp_wv || win_ready);
          exp_fe = 1'b0;
          if (m_con) begin
            if (last_q.size() > 0) begin
              exp_fe = last_q[0];
              void'(last_q.pop_front());
            end
            if (sb_q.size() > 0) void'(sb_q.pop_front());
            exp_wv = 1'b0;
          end
          if (m_acc) begin
            img[m_row][m_col] = pix_in;
            if (m_row >= 2 && m_col >= 2) begin
              sb_q.push_back({img[m_row-2][m_col-2], img[m_row-2][m_col-1], img[m_row-2][m_col],
                              img[m_row-1][m_col-2], img[m_row-1][m_col-1], img[m_row-1][m_col],
                              img[m_row][m_col-2],   img[m_row][m_col-1],   img[m_row][m_col]});
              last_q.push_back(m_row == H-1 && m_col == W-1);
              exp_wv = 1'b1;
            end
            if (m_col == W-1) begin
              m_col = 0;
              m_row = (m_row == H-1) ? 0 : m_row + 1;
            end else begin
              m_col++;
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] v);
    int budget = 100;
    pix_valid = 1'b1;
    pix_in    = v;
    #2;
    while (!pix_ready && budget > 0) begin
      tick();
      #2;
      budget--;
    end
    if (!pix_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: pix_ready %0b, required 1 for pixel %0d", pix_ready, v);
      pix_valid = 1'b0;
    end
    tick();
  endtask

  task automatic send_range(input int base, input int first, input int last);
    for (int p = first; p <= last; p++) send(8'(base + p));
  endtask

  task automatic idle(input int n);
    pix_valid = 1'b0;
    repeat (n) tick();
  endtask

  logic [71:0] snap;
  logic [71:0] exp_k;
  logic [71:0] cap;
  int          n0;

  initial begin
    tbl[0] = '{12, 8'd0,  8'd6,  8'd12};
    tbl[1] = '{13, 8'd1,  8'd7,  8'd13};
    tbl[2] = '{14, 8'd2,  8'd8,  8'd14};
    tbl[3] = '{17, 8'd5,  8'd11, 8'd17};
    tbl[4] = '{18, 8'd6,  8'd12, 8'd18};
    tbl[5] = '{19, 8'd7,  8'd13, 8'd19};
    tbl[6] = '{22, 8'd10, 8'd16, 8'd22};
    tbl[7] = '{23, 8'd11, 8'd17, 8'd23};
    tbl[8] = '{24, 8'd12, 8'd18, 8'd24};
`ifdef CONV_WIN_KERNEL_LOAD_EN
    exp_k = K_LOADED;
`else
    exp_k = K_IDENT;
`endif

    reset = 1'b1; pix_valid = 1'b0; pix_in = '0;
    win_ready = 1'b1; k_in = '0; k_load = 1'b0;
    repeat (3) @(posedge clk);
    mon_en = 1'b1;
    #1 reset = 1'b0;

    chk("rst_pix_ready", 72'(pix_ready), 72'd1);
    chk("rst_x", xvec(), 72'd0);
    chk("rst_win_valid", 72'(win_valid), 72'd0);
    chk("rst_frame_end", 72'(frame_end), 72'd0);
`ifdef CONV_WIN_KERNEL_LOAD_EN
    chk("rst_kernel", kvec(), 72'd0);
`else
    chk("rst_kernel", kvec(), K_IDENT);
`endif

    // Frame 1, win_ready held high; compare captured windows to the table.
    send_range(0, 0, 24);
    idle(4);
    chk("f1_windows", 72'(win_cnt), 72'd9);
    chk("f1_frame_end", 72'(fe_cnt), 72'd1);
    for (int i = 0; i < 9; i++) begin
      cap = (cap_log.size() > i) ? cap_log[i] : '1;
      chk($sformatf("tbl%0d_pix%0d_x11", i, tbl[i].done_pix), 72'(cap[71:64]), 72'(tbl[i].e11));
      chk($sformatf("tbl%0d_pix%0d_x22", i, tbl[i].done_pix), 72'(cap[39:32]), 72'(tbl[i].e22));
      chk($sformatf("tbl%0d_pix%0d_x33", i, tbl[i].done_pix), 72'(cap[7:0]),   72'(tbl[i].e33));
    end

    // Back-pressure on the first window for 5 cycles.
    win_ready = 1'b0;
    send_range(0, 0, 12);
    pix_in = 8'd13;
    snap = xvec();
    chk("bp_win_valid", 72'(win_valid), 72'd1);
    chk("bp_first_window", snap, WIN_F0);
    repeat (5) begin
      #2;
      chk("bp_pix_ready", 72'(pix_ready), 72'd0);
      chk("bp_x_stable", xvec(), snap);
      tick();
    end
    win_ready = 1'b1;
    #2;
    chk("bp_release_ready", 72'(pix_ready), 72'd1);
    tick();
    pix_valid = 1'b0;
    chk("bp_next_window", xvec(), WIN_F0_N);
    chk("bp_wv_after", 72'(win_valid), 72'd1);
    send_range(0, 14, 24);
    idle(4);
    chk("bp_windows", 72'(win_cnt), 72'd18);
    chk("bp_frame_end", 72'(fe_cnt), 72'd2);

    // Back-to-back frames, second offset by 100.
    n0 = win_cnt;
    send_range(0, 0, 24);
    send_range(100, 0, 24);
    idle(4);
    cap = (cap_log.size() > n0 + 9) ? cap_log[n0+9] : '1;
    chk("b2b_first_f2", cap, WIN_F100);
    chk("b2b_windows", 72'(win_cnt), 72'd36);
    chk("b2b_frame_end", 72'(fe_cnt), 72'd4);

    // Reset after pixel 8, then a restarted frame.
    send_range(0, 0, 8);
    pix_valid = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    chk("mrst_x", xvec(), 72'd0);
    chk("mrst_win_valid", 72'(win_valid), 72'd0);
    chk("mrst_frame_end", 72'(frame_end), 72'd0);
    reset = 1'b0;
    send_range(0, 0, 11);
    chk("mrst_no_early_win", 72'(win_valid), 72'd0);
    send(8'd12);
    chk("mrst_first_win_valid", 72'(win_valid), 72'd1);
    chk("mrst_first_window", xvec(), WIN_F0);
    send_range(0, 13, 24);
    idle(4);
    chk("mrst_windows", 72'(win_cnt), 72'd45);
    chk("mrst_frame_end", 72'(fe_cnt), 72'd5);

    // Kernel load, then a load attempt while a window is pending.
    k_load = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      k_in = 8'(i);
      tick();
    end
    k_load = 1'b0;
    chk("k_after_load", kvec(), exp_k);
    win_ready = 1'b0;
    send_range(0, 0, 12);
    pix_valid = 1'b0;
    k_in   = 8'hAA;
    k_load = 1'b1;
    tick();
    k_load = 1'b0;
    chk("k_hold_win_valid", 72'(win_valid), 72'd1);
    chk("k_hold", kvec(), exp_k);
    win_ready = 1'b1;
    send_range(0, 13, 24);
    idle(4);
    chk("end_windows", 72'(win_cnt), 72'd54);
    chk("end_frame_end", 72'(fe_cnt), 72'd6);
    chk("end_sb_empty", 72'(sb_q.size()), 72'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
